// File: rtl/filter_loader.sv
// filter_loader: fetches KxK filters then bias words from weight memory and writes them into the filter buffer
module filter_loader #(
    parameter int DATA_W = 16,
    parameter int K = 5,
    parameter int ADDR_W = 16,
    parameter int IDX_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [IDX_W-1:0]      num_filters,
    input  logic [IDX_W-1:0]      num_bias,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_valid,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  FB_write,
    output logic                  FB_bias_or_filter,
    output logic [K*K*DATA_W-1:0] FB_filter,
    output logic [IDX_W-1:0]      FB_index_filter,
    output logic [IDX_W-1:0]      FB_index_bias,
    output logic [DATA_W-1:0]     FB_bias_data,
    output logic                  busy,
    output logic                  done
);
    localparam int N = K * K;
    localparam int WC_W = $clog2(N + 1);
    typedef enum logic [2:0] {IDLE, F_REQ, F_WAIT, F_WR, B_REQ, B_WAIT, B_WR, FIN} state_t;
    state_t state, next;
    logic [ADDR_W-1:0] addr;
    logic [WC_W-1:0] word_cnt;
    logic [IDX_W-1:0] filt_cnt, bias_cnt, n_filt, n_bias;
    logic last_word, last_filt, last_bias;
    assign last_word = word_cnt == WC_W'(N - 1);
    assign last_filt = filt_cnt == n_filt - IDX_W'(1);
    assign last_bias = bias_cnt == n_bias - IDX_W'(1);
    assign mem_addr = addr;
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        mem_rd = 1'b0;
        FB_write = 1'b0;
        case (state)
            IDLE: if (start) next = num_filters != '0 ? F_REQ : num_bias != '0 ? B_REQ : FIN;
            F_REQ: begin
                mem_rd = 1'b1;
                next = F_WAIT;
            end
            F_WAIT: if (mem_valid) next = last_word ? F_WR : F_REQ;
            F_WR: begin
                FB_write = 1'b1;
                next = !last_filt ? F_REQ : n_bias != '0 ? B_REQ : FIN;
            end
            B_REQ: begin
                mem_rd = 1'b1;
                next = B_WAIT;
            end
            B_WAIT: if (mem_valid) next = B_WR;
            B_WR: begin
                FB_write = 1'b1;
                next = last_bias ? FIN : B_REQ;
            end
            FIN: next = IDLE;
            default: next = IDLE;
        endcase
    end
    // Buffer-facing registers only change on captures, so they hold between write strobes
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr <= '0;
            word_cnt <= '0;
            filt_cnt <= '0;
            bias_cnt <= '0;
            n_filt <= '0;
            n_bias <= '0;
            FB_filter <= '0;
            FB_index_filter <= '0;
            FB_index_bias <= '0;
            FB_bias_data <= '0;
            FB_bias_or_filter <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= state == FIN;
            case (state)
                IDLE: if (start) begin
                    addr <= base_addr;
                    n_filt <= num_filters;
                    n_bias <= num_bias;
                    word_cnt <= '0;
                    filt_cnt <= '0;
                    bias_cnt <= '0;
                    busy <= 1'b1;
                end
                F_WAIT: if (mem_valid) begin
                    FB_filter[int'(word_cnt) * DATA_W +: DATA_W] <= mem_data;
                    addr <= addr + 1'b1;
                    word_cnt <= last_word ? '0 : word_cnt + 1'b1;
                    if (last_word) begin
                        FB_index_filter <= filt_cnt;
                        FB_bias_or_filter <= 1'b1;
                    end
                end
                F_WR: filt_cnt <= filt_cnt + 1'b1;
                B_WAIT: if (mem_valid) begin
                    FB_bias_data <= mem_data;
                    FB_index_bias <= bias_cnt;
                    FB_bias_or_filter <= 1'b0;
                    addr <= addr + 1'b1;
                end
                B_WR: bias_cnt <= bias_cnt + 1'b1;
                FIN: busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_filter_loader.sv
// tb_filter_loader: directed loads against a latency-configurable memory model, checked by a write/read/done scoreboard
module tb_filter_loader;
    localparam int DW = 16, K = 5, AW = 16, IW = 16, N = K * K;
    logic clk = 0, reset = 0, start = 0, mem_valid = 0;
    logic [AW-1:0] base_addr = 0;
    logic [IW-1:0] num_filters = 0, num_bias = 0;
    logic [DW-1:0] mem_data = 0;
    logic mem_rd, FB_write, FB_bias_or_filter, busy, done;
    logic [AW-1:0] mem_addr;
    logic [N*DW-1:0] FB_filter;
    logic [IW-1:0] FB_index_filter, FB_index_bias;
    logic [DW-1:0] FB_bias_data;

    typedef struct {
        logic bof;
        logic [IW-1:0] idx;
        logic [N*DW-1:0] filt;
        logic [DW-1:0] bias;
    } wr_t;
    wr_t wr_q[$];
    wr_t w;
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] a;
    int done_q[$];
    int dexp;
    int checks = 0, passes = 0, cyc = 0, lat = 1, cnt = 0, rd_count = 0, spur_at = -1;
    logic outstanding = 0;
    logic [AW-1:0] rd_addr = 0, mem_base = 0;

    filter_loader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_filters(num_filters), .num_bias(num_bias), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_data(mem_data), .FB_write(FB_write),
        .FB_bias_or_filter(FB_bias_or_filter), .FB_filter(FB_filter),
        .FB_index_filter(FB_index_filter), .FB_index_bias(FB_index_bias),
        .FB_bias_data(FB_bias_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input bit ok, input string got, input string want);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    // Memory word at address x holds x - mem_base; spur_at injects a bogus valid alongside that read request
    always @(negedge clk) begin
        mem_valid = 0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                mem_valid = 1;
                mem_data = rd_addr - mem_base;
                outstanding = 0;
            end
        end
        if (mem_rd === 1'b1) begin
            check("rd_protocol", !outstanding, "read while previous outstanding", "one read in flight");
            if (addr_q.size() == 0) check("unexpected_rd", 0, $sformatf("read at %h", mem_addr), "no read");
            else begin
                a = addr_q.pop_front();
                check("rd_addr", mem_addr === a, $sformatf("%h", mem_addr), $sformatf("%h", a));
            end
            outstanding = 1;
            rd_addr = mem_addr;
            cnt = lat;
            rd_count++;
            if (rd_count == spur_at) begin
                mem_valid = 1;
                mem_data = 16'h7777;
            end
        end
    end

    always @(negedge clk) begin
        if (FB_write === 1'b1) begin
            if (wr_q.size() == 0) check("unexpected_write", 0, $sformatf("write bof=%0d", FB_bias_or_filter), "no write");
            else begin
                w = wr_q.pop_front();
                if (w.bof)
                    check("filter_write", FB_bias_or_filter === 1'b1 && FB_index_filter === w.idx && FB_filter === w.filt,
                          $sformatf("bof=%0d idx=%0d filt=%h", FB_bias_or_filter, FB_index_filter, FB_filter),
                          $sformatf("bof=1 idx=%0d filt=%h", w.idx, w.filt));
                else
                    check("bias_write", FB_bias_or_filter === 1'b0 && FB_index_bias === w.idx && FB_bias_data === w.bias,
                          $sformatf("bof=%0d idx=%0d data=%0d", FB_bias_or_filter, FB_index_bias, FB_bias_data),
                          $sformatf("bof=0 idx=%0d data=%0d", w.idx, w.bias));
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) check("unexpected_done", 0, $sformatf("done at cycle %0d", cyc), "no done");
            else begin
                dexp = done_q.pop_front();
                check("done_cycle", cyc == dexp, $sformatf("%0d", cyc), $sformatf("%0d", dexp));
            end
        end
    end

    // cut >= 0 models a load abandoned after that many reads: only completed writes and issued reads are expected
    task automatic run(input logic [AW-1:0] base, input int nf, input int nb, input int l, input int cut);
        int lim;
        wr_t e;
        lim = cut < 0 ? nf * N + nb : cut;
        lat = l;
        mem_base = base;
        rd_count = 0;
        for (int i = 0; i < lim; i++) addr_q.push_back(AW'(base + i));
        for (int f = 0; f < nf; f++) if ((f + 1) * N <= lim) begin
            e.bof = 1;
            e.idx = IW'(f);
            e.bias = 0;
            e.filt = '0;
            for (int i = 0; i < N; i++) e.filt[i*DW +: DW] = DW'(f * N + i);
            wr_q.push_back(e);
        end
        for (int b = 0; b < nb; b++) if (nf * N + b + 1 <= lim) begin
            e.bof = 0;
            e.idx = IW'(b);
            e.bias = DW'(nf * N + b);
            wr_q.push_back(e);
        end
        @(negedge clk);
        if (cut < 0) done_q.push_back(cyc + nf * (N * (l + 1) + 1) + nb * (l + 2) + 2);
        base_addr = base;
        num_filters = IW'(nf);
        num_bias = IW'(nb);
        start = 1;
        @(negedge clk);
        start = 0;
        check("busy_after_start", busy === 1'b1, $sformatf("%b", busy), "1");
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        check("done_seen", i < budget, "no done within budget", "done");
        repeat (3) @(negedge clk);
        check("drain", wr_q.size() == 0 && addr_q.size() == 0 && done_q.size() == 0 && busy === 1'b0,
              $sformatf("wr=%0d rd=%0d done=%0d busy=%b", wr_q.size(), addr_q.size(), done_q.size(), busy),
              "all empty, busy=0");
    endtask

    task automatic check_idle(input string name);
        check(name, {mem_rd, FB_write, busy, done} === 4'b0 && FB_bias_or_filter === 1'b1 && mem_addr === '0 &&
              FB_filter === '0 && FB_index_filter === '0 && FB_index_bias === '0 && FB_bias_data === '0,
              $sformatf("rd=%b wr=%b busy=%b done=%b bof=%b addr=%h fidx=%0d bidx=%0d bdata=%0d filt_zero=%b",
                        mem_rd, FB_write, busy, done, FB_bias_or_filter, mem_addr, FB_index_filter,
                        FB_index_bias, FB_bias_data, FB_filter === '0),
              "all zero, bof=1");
    endtask

    initial begin
        int i;
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (5) @(negedge clk);
        check_idle("reset_state");
        run(16'h0100, 1, 0, 1, -1);
        wait_done(200);
        run(16'h0200, 6, 6, 3, -1);
        wait_done(1000);
        run(16'h0000, 0, 0, 1, -1);
        wait_done(20);
        spur_at = 3;
        run(16'hFFF0, 1, 0, 1, -1);
        wait_done(200);
        spur_at = -1;
        run(16'h0300, 3, 1, 1, 2 * N + 13);
        for (i = 0; i < 500 && rd_count < 2 * N + 13; i++) @(posedge clk);
        check("reset_point_reached", i < 500, $sformatf("%0d reads", rd_count), $sformatf("%0d reads", 2 * N + 13));
        #1 reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_idle("after_mid_reset");
        repeat (60) @(negedge clk);
        check("mid_reset_drain", wr_q.size() == 0 && addr_q.size() == 0 && busy === 1'b0,
              $sformatf("wr=%0d rd=%0d busy=%b", wr_q.size(), addr_q.size(), busy), "empty, idle");
        run(16'h0400, 1, 2, 2, -1);
        repeat (10) @(negedge clk);
        base_addr = 16'h5000;
        num_filters = 4;
        num_bias = 4;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(300);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
